// File: rtl/msdf_test_pipeline_pkg.sv
// Shared types and helpers for the MSDF test pipeline: FSM encoding and the
// read-to-write alignment latency.
package msdf_test_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIssue  = 2'd1,
      StDrain  = 2'd2,
      StFinish = 2'd3
   } state_e;

   // Operand RAM read, input register, DUT, output register.
   function automatic int unsigned test_latency(input int unsigned rd_latency,
                                                input int unsigned dut_latency);
      return rd_latency + 32'd1 + dut_latency + 32'd1;
   endfunction

endpackage

// File: rtl/msdf_test_pipeline_if.sv
// Operand read, DUT and result write buses of the MSDF test pipeline.
// master = pipeline side, slave = RAM/DUT side.
interface msdf_test_pipeline_if #(
   parameter int unsigned IN_WIDTH   = 30,
   parameter int unsigned OUT_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH = 11
);
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [IN_WIDTH-1:0]   rd_data_x;
   logic [IN_WIDTH-1:0]   rd_data_y;
   logic [IN_WIDTH-1:0]   dut_x;
   logic [IN_WIDTH-1:0]   dut_y;
   logic [OUT_WIDTH-1:0]  dut_s;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [OUT_WIDTH-1:0]  wr_data;

   modport master (
      output rd_en, rd_addr, dut_x, dut_y, wr_en, wr_addr, wr_data,
      input  rd_data_x, rd_data_y, dut_s
   );

   modport slave (
      input  rd_en, rd_addr, dut_x, dut_y, wr_en, wr_addr, wr_data,
      output rd_data_x, rd_data_y, dut_s
   );
endinterface

// File: rtl/msdf_test_pipeline_pipe_delay.sv
// Resettable shift-register delay of DEPTH cycles; DEPTH=0 degenerates to a wire.
module pipe_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   if (DEPTH == 0) begin : g_wire
      assign q_o = d_i;
   end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
         end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end
endmodule

// File: rtl/msdf_test_pipeline.sv
// Streams operand pairs from the operand RAMs through an MSDF unit into a result RAM;
// write strobe/address are the read strobe/address delayed by the full datapath latency.
module msdf_test_pipeline
   import msdf_test_pkg::*;
#(
   parameter int unsigned IN_WIDTH    = 30,
   parameter int unsigned OUT_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH  = 11,
   parameter int unsigned RD_LATENCY  = 1,
   parameter int unsigned DUT_LATENCY = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic                 loop_mode_i,
   input  logic [ADDR_WIDTH:0]  num_samples_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [31:0]          pass_count_o,
   msdf_test_pipeline_if.master bus_io
);
   localparam int unsigned L = test_latency(RD_LATENCY, DUT_LATENCY);
   // L >= 2 always, so L-1 fits in clog2(L) bits.
   localparam int unsigned DrainW = $clog2(L);
   localparam logic [DrainW-1:0] DrainLast = DrainW'(L - 1);
   localparam logic [ADDR_WIDTH:0] MaxSamples = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_e state_q, state_d;
   logic [ADDR_WIDTH:0] n_q, n_d, addr_q, addr_d, n_clamped;
   logic [DrainW-1:0]   drain_q, drain_d;
   logic [31:0]         pass_q, pass_d;
   logic                loop_q, loop_d, done_q, done_d;
   logic                accept, last_addr, rd_en;
   logic [ADDR_WIDTH:0] wr_tag;
   logic [IN_WIDTH-1:0] dut_x_q, dut_y_q;
   logic [OUT_WIDTH-1:0] wr_data_q;

   assign n_clamped = (num_samples_i > MaxSamples) ? MaxSamples : num_samples_i;
   assign accept    = (state_q == StIdle) && start_i && !abort_i;
   assign last_addr = (addr_q == n_q - 1'b1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = (n_clamped == '0) ? StFinish : StIssue;
         StIssue:  if (abort_i || (last_addr && !loop_q)) state_d = StDrain;
         StDrain:  if (drain_q == DrainLast) state_d = StFinish;
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      rd_en  = 1'b0;
      busy_o = 1'b0;
      unique case (state_q)
         StIssue: begin
            rd_en  = 1'b1;
            busy_o = 1'b1;
         end
         StDrain: busy_o = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      n_d     = n_q;
      loop_d  = loop_q;
      addr_d  = addr_q;
      pass_d  = pass_q;
      done_d  = done_q;
      drain_d = (state_q == StDrain) ? drain_q + 1'b1 : '0;
      if (accept) begin
         n_d    = n_clamped;
         loop_d = loop_mode_i;
         addr_d = '0;
         pass_d = '0;
         done_d = 1'b0;
      end
      if (state_q == StIssue) begin
         addr_d = last_addr ? '0 : addr_q + 1'b1;
         // A pass counts once its final address has been issued, even if abort lands then.
         if (last_addr && pass_q != '1) pass_d = pass_q + 32'd1;
      end
      if (state_d == StFinish) done_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n_q       <= '0;
         loop_q    <= 1'b0;
         addr_q    <= '0;
         drain_q   <= '0;
         pass_q    <= '0;
         done_q    <= 1'b0;
         dut_x_q   <= '0;
         dut_y_q   <= '0;
         wr_data_q <= '0;
      end else begin
         n_q       <= n_d;
         loop_q    <= loop_d;
         addr_q    <= addr_d;
         drain_q   <= drain_d;
         pass_q    <= pass_d;
         done_q    <= done_d;
         dut_x_q   <= bus_io.rd_data_x;
         dut_y_q   <= bus_io.rd_data_y;
         wr_data_q <= bus_io.dut_s;
      end
   end

   pipe_delay #(
      .WIDTH (ADDR_WIDTH + 1),
      .DEPTH (L)
   ) u_wr_delay (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    ({rd_en, addr_q[ADDR_WIDTH-1:0]}),
      .q_o    (wr_tag)
   );

   assign bus_io.rd_en   = rd_en;
   assign bus_io.rd_addr = addr_q[ADDR_WIDTH-1:0];
   assign bus_io.dut_x   = dut_x_q;
   assign bus_io.dut_y   = dut_y_q;
   assign bus_io.wr_en   = wr_tag[ADDR_WIDTH];
   assign bus_io.wr_addr = wr_tag[ADDR_WIDTH-1:0];
   assign bus_io.wr_data = wr_data_q;
   assign done_o         = done_q;
   assign pass_count_o   = pass_q;
endmodule

// File: tb/tb_msdf_test_pipeline.sv
// Directed bench for msdf_test_pipeline: registered operand RAMs, 3-cycle adder DUT model,
// a vector table of runs plus hand-written reset/handshake corner sequences.
module tb_msdf_test_pipeline;
   localparam int unsigned InW    = 30;
   localparam int unsigned OutW   = 32;
   localparam int unsigned AddrW  = 4;
   localparam int unsigned RdLat  = 1;
   localparam int unsigned DutLat = 3;
   localparam int L = RdLat + 1 + DutLat + 1;
   localparam int NumVecs = 8;

   typedef struct {
      int n;
      int lp;
      int abort_at;
      int start_at;
      int exp_reads;
      int exp_pc;
      int exp_mod;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic loop_mode = 1'b0;
   logic [AddrW:0] num_samples = '0;
   logic busy, done;
   logic [31:0] pass_count;
   logic [InW-1:0] x_mem [16];
   logic [InW-1:0] y_mem [16];
   logic [OutW-1:0] sum_q [3];
   vec_t vecs [NumVecs];
   int checks = 0;
   int errors = 0;
   int stray;

   msdf_test_pipeline_if #(.IN_WIDTH(InW), .OUT_WIDTH(OutW), .ADDR_WIDTH(AddrW)) bus ();

   msdf_test_pipeline #(
      .IN_WIDTH    (InW),
      .OUT_WIDTH   (OutW),
      .ADDR_WIDTH  (AddrW),
      .RD_LATENCY  (RdLat),
      .DUT_LATENCY (DutLat)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .abort_i       (abort),
      .loop_mode_i   (loop_mode),
      .num_samples_i (num_samples),
      .busy_o        (busy),
      .done_o        (done),
      .pass_count_o  (pass_count),
      .bus_io        (bus)
   );

   always #5 clk = ~clk;

   // Operand RAMs with one cycle of read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_data_x <= '0;
         bus.rd_data_y <= '0;
      end else if (bus.rd_en) begin
         bus.rd_data_x <= x_mem[bus.rd_addr];
         bus.rd_data_y <= y_mem[bus.rd_addr];
      end
   end

   // Adder under test: three register stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q[0] <= '0;
         sum_q[1] <= '0;
         sum_q[2] <= '0;
      end else begin
         sum_q[0] <= {2'b00, bus.dut_x} + {2'b00, bus.dut_y};
         sum_q[1] <= sum_q[0];
         sum_q[2] <= sum_q[1];
      end
   end
   assign bus.dut_s = sum_q[2];

   function automatic logic [OutW-1:0] exp_sum(input int a);
      return {2'b00, x_mem[a]} + {2'b00, y_mem[a]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pulse start, then sample every cycle at the falling edge; cycle 1 is the first after start.
   task automatic run_case(input int idx, input vec_t v);
      int reads, writes, done_cyc, exp_a, exp_done;
      int rd_cyc [64];
      bit fin, aborted;
      reads = 0;
      writes = 0;
      done_cyc = -1;
      fin = 1'b0;
      aborted = 1'b0;
      @(negedge clk);
      num_samples = (AddrW + 1)'(v.n);
      loop_mode = v.lp[0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 300 && !fin; c++) begin
         if (bus.rd_en) begin
            check($sformatf("v%0d rd_addr[%0d]", idx, reads), bus.rd_addr, reads % v.exp_mod);
            check($sformatf("v%0d rd_cycle[%0d]", idx, reads), c, reads + 1);
            if (reads < 64) rd_cyc[reads] = c;
            reads++;
         end
         if (bus.wr_en) begin
            exp_a = writes % v.exp_mod;
            if (writes < reads && writes < 64) begin
               check($sformatf("v%0d wr_addr[%0d]", idx, writes), bus.wr_addr, exp_a);
               check($sformatf("v%0d wr_data[%0d]", idx, writes), bus.wr_data, exp_sum(exp_a));
               check($sformatf("v%0d wr_cycle[%0d]", idx, writes), c, rd_cyc[writes] + L);
            end else begin
               check($sformatf("v%0d unmatched wr_en", idx), 1, 0);
            end
            writes++;
         end
         if (done_cyc < 0 && done === 1'b1) begin
            done_cyc = c;
            check($sformatf("v%0d busy at done", idx), busy, 0);
            check($sformatf("v%0d pass_count", idx), pass_count, v.exp_pc);
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) fin = 1'b1;
         abort = 1'b0;
         if (v.abort_at > 0 && reads == v.abort_at && !aborted) begin
            abort = 1'b1;
            aborted = 1'b1;
         end
         start = (v.start_at == c);
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      exp_done = (v.exp_reads == 0) ? 1 : v.exp_reads + L + 1;
      check($sformatf("v%0d finished in budget", idx), fin, 1);
      check($sformatf("v%0d read count", idx), reads, v.exp_reads);
      check($sformatf("v%0d write count", idx), writes, v.exp_reads);
      check($sformatf("v%0d done cycle", idx), done_cyc, exp_done);
   endtask

   initial begin
      //             n  lp abort start reads pc  mod
      vecs[0] = '{ 4, 0, 0,    0,    4,    1,  4};
      vecs[1] = '{ 0, 0, 0,    0,    0,    0,  1};
      vecs[2] = '{ 3, 1, 8,    0,    8,    2,  3};
      vecs[3] = '{ 8, 0, 0,    3,    8,    1,  8};
      vecs[4] = '{16, 0, 0,    0,   16,    1, 16};
      vecs[5] = '{20, 0, 0,    0,   16,    1, 16};
      vecs[6] = '{ 5, 1, 12,   0,   12,    2,  5};
      vecs[7] = '{ 1, 0, 0,    0,    1,    1,  1};
      for (int i = 0; i < 16; i++) begin
         x_mem[i] = InW'(32'h2345_6789 * (i + 1));
         y_mem[i] = InW'(32'h3FFF_FF00 - 32'(i * 13));
      end

      #1 rst_n = 1'b0;
      #2;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset pass_count", pass_count, 0);
      check("reset rd_en", bus.rd_en, 0);
      check("reset rd_addr", bus.rd_addr, 0);
      check("reset wr_en", bus.wr_en, 0);
      check("reset wr_addr", bus.wr_addr, 0);
      check("reset wr_data", bus.wr_data, 0);
      check("reset dut_x", bus.dut_x, 0);
      check("reset dut_y", bus.dut_y, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NumVecs; i++) run_case(i, vecs[i]);

      // start together with abort while idle must be ignored; done stays sticky.
      @(negedge clk);
      num_samples = 5'd4;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("start+abort busy[%0d]", k), busy, 0);
         check($sformatf("start+abort rd_en[%0d]", k), bus.rd_en, 0);
         @(negedge clk);
      end
      check("start+abort done kept", done, 1);

      // Asynchronous reset in the middle of issuing.
      num_samples = 5'd10;
      loop_mode = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid-run busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst busy", busy, 0);
      check("async rst rd_en", bus.rd_en, 0);
      check("async rst rd_addr", bus.rd_addr, 0);
      check("async rst wr_en", bus.wr_en, 0);
      check("async rst done", done, 0);
      check("async rst pass_count", pass_count, 0);
      check("async rst dut_x", bus.dut_x, 0);
      check("async rst wr_data", bus.wr_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0) stray++;
      end
      check("strobes after reset", stray, 0);
      run_case(100, vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
